// File: rtl/ifetch_queue.sv
// Pipelined instruction-fetch front end: credit-limited imem reads feeding a
// DEPTH-entry instruction/PC FIFO, with redirect flush and stale-response drop.
module ifetch_queue #(
  parameter int                N_BITS          = 32,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [N_BITS-1:0] RESET_PC        = '0,
  parameter int                OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_vld,
  input  logic              imem_req_rdy,
  output logic              imem_req_mtype,
  output logic [N_BITS-1:0] imem_req_addr,
  output logic [1:0]        imem_req_len,
  output logic [N_BITS-1:0] imem_req_data,
  input  logic              imem_rsp_vld,
  output logic              imem_rsp_rdy,
  input  logic [N_BITS-1:0] imem_rsp_data,
  input  logic              redirect_vld,
  input  logic [N_BITS-1:0] redirect_pc,
  output logic              instr_vld,
  input  logic              instr_rdy,
  output logic [N_BITS-1:0] instr,
  output logic [N_BITS-1:0] instr_pc,
  output logic [N_BITS-1:0] instr_pc_plus4,
  output logic [OW-1:0]     outstanding
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = AW + 2;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic              MTYPE_READ = 1'b0;
  localparam logic [LW-1:0]     DEPTH_L    = LW'(DEPTH);
  localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);
  localparam logic [OW-1:0]     MAXO_L     = OW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0]     PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
  localparam logic [N_BITS-1:0] PC_STEP    = N_BITS'(4);

  logic [N_BITS-1:0] r_fetch_pc;
  logic [OW-1:0]     r_outstanding;
  logic [OW-1:0]     r_drop_cnt;
  logic [N_BITS-1:0] r_fifo_instr [DEPTH];
  logic [N_BITS-1:0] r_fifo_pc    [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [N_BITS-1:0] r_if_pc [MAX_OUTSTANDING];
  logic [PW-1:0]     r_if_wr;
  logic [PW-1:0]     r_if_rd;

  logic [LW-1:0]     w_live;
  logic              w_req_fire;
  logic              w_rsp_fire;
  logic              w_rsp_drop;
  logic              w_push;
  logic              w_pop;
  logic [OW-1:0]     w_out_next;
  logic [N_BITS-1:0] w_rsp_pc;

  // Credit counts every slot a response could still claim, so the FIFO never overflows.
  assign w_live = LW'(r_outstanding) - LW'(r_drop_cnt) + LW'(r_count);

  assign imem_req_vld   = rst_n && !redirect_vld && (w_live < DEPTH_L) && (r_outstanding < MAXO_L);
  assign imem_req_mtype = MTYPE_READ;
  assign imem_req_addr  = r_fetch_pc;
  assign imem_req_len   = 2'b00;
  assign imem_req_data  = '0;
  assign imem_rsp_rdy   = rst_n;

  assign w_req_fire = imem_req_vld && imem_req_rdy;
  assign w_rsp_fire = imem_rsp_vld && imem_rsp_rdy;
  assign w_rsp_drop = (r_drop_cnt != '0) || redirect_vld;
  assign w_push     = w_rsp_fire && !w_rsp_drop;
  assign w_pop      = instr_vld && instr_rdy;
  assign w_out_next = r_outstanding + OW'(w_req_fire) - OW'(w_rsp_fire);
  assign w_rsp_pc   = r_if_pc[r_if_rd];

  assign instr_vld      = (r_count != '0) && !redirect_vld;
  assign instr          = r_fifo_instr[r_rd_ptr];
  assign instr_pc       = r_fifo_pc[r_rd_ptr];
  assign instr_pc_plus4 = r_fifo_pc[r_rd_ptr] + PC_STEP;
  assign outstanding    = r_outstanding;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_if_wr       <= '0;
      r_if_rd       <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_req_fire) begin
        r_if_wr <= (r_if_wr == PTR_LAST) ? '0 : r_if_wr + 1'b1;
      end
      if (w_rsp_fire) begin
        r_if_rd <= (r_if_rd == PTR_LAST) ? '0 : r_if_rd + 1'b1;
      end
      // Redirect marks everything still in flight after this cycle as stale.
      if (redirect_vld) begin
        r_fetch_pc <= redirect_pc;
        r_drop_cnt <= w_out_next;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
        if (w_rsp_fire && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - 1'b1;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]    <= w_rsp_pc;
    end
    if (w_req_fire) begin
      r_if_pc[r_if_wr] <= r_fetch_pc;
    end
  end

  a_out_bound:  assert property (@(posedge clk) disable iff (!rst_n) r_outstanding <= MAXO_L);
  a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n) r_drop_cnt <= r_outstanding);
  a_fifo_bound: assert property (@(posedge clk) disable iff (!rst_n) r_count <= DEPTH_C);
  a_rsp_under:  assert property (@(posedge clk) disable iff (!rst_n) !(w_rsp_fire && r_outstanding == '0));
  a_fifo_over:  assert property (@(posedge clk) disable iff (!rst_n) !(w_push && !w_pop && r_count == DEPTH_C));

endmodule
